alu_issue_seq: RTL

- Operand-issue and writeback sequencer that wraps the 8-bit combinational ALU (x, y, sel in; out, zero, carry, overflow, negative back).
- Holds a small register file and accepts one instruction at a time over a valid/ready handshake.
- Drives registered operands and select into the ALU, then writes the result to a destination register and latches the flags.
- Sits directly upstream of the ALU (feeds it) and directly downstream of it (consumes its outputs).

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_regfile.sv | 35 +++
 rtl/alu_issue_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes, state encoding and flag indices for the ALU sequencer
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int NREGS  = 4;
  localparam int ADDR_W = 2;

  localparam logic [3:0] OP_LDI = 4'd15;

  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - general register file, one write port and three combinational read ports
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  // Register storage: cleared by reset, written on the writeback edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o   = regs_q[raddr1_i];
  assign rdata2_o   = regs_q[raddr2_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - operand issue and writeback sequencer wrapped around the combinational ALU
module alu_issue_seq
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              alu_negative,
  output logic [3:0]        flags,
  output logic              done,
  output logic              busy,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  logic [3:0]        sel_q, sel_d;
  logic [3:0]        flags_q, flags_d;
  logic              done_q, done_d;

  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;

  // LDI bypasses the ALU result entirely; everything else writes back what the ALU settled on
  assign rf_wdata = (op_q == OP_LDI) ? imm_q : alu_out;

  alu_regfile u_regfile (
    .clk        (clk),
    .rst        (rst),
    .we_i       (rf_we),
    .waddr_i    (rd_q),
    .wdata_i    (rf_wdata),
    .raddr1_i   (in_rs1),
    .raddr2_i   (in_rs2),
    .dbg_addr_i (dbg_addr),
    .rdata1_o   (rs1_data),
    .rdata2_o   (rs2_data),
    .dbg_data_o (dbg_data)
  );

  // State and datapath registers; reset discards any in-flight instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sel_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

  // Next-state: accept in IDLE, write back in EXEC, pulse done through DONE
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    x_d     = x_q;
    y_d     = y_q;
    sel_d   = sel_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    rf_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d   = rs1_data;
          y_d   = rs2_data;
          op_d  = in_op;
          rd_d  = in_rd;
          imm_d = in_imm;
          if (in_op != OP_LDI) begin
            sel_d = in_op;
          end
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rf_we = 1'b1;
        if (op_q != OP_LDI) begin
          flags_d[FLG_Z] = alu_zero;
          flags_d[FLG_C] = alu_carry;
          flags_d[FLG_V] = alu_overflow;
          flags_d[FLG_N] = alu_negative;
        end
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign alu_x    = x_q;
  assign alu_y    = y_q;
  assign alu_sel  = sel_q;
  assign flags    = flags_q;

endmodule
